// File: rtl/piso_tx_if.sv
// Parallel-word / serial-bit bundle between a word source and the piso_tx
// transmitter. The master drives words in; the slave (the transmitter)
// reports flow control and drives the serial line.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             dout;
  logic             bit_en;
  logic             busy;
  logic             done;

  modport master (
    output din,
    output load,
    input  ready,
    input  dout,
    input  bit_en,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output dout,
    output bit_en,
    output busy,
    output done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter. Shifts a WIDTH-bit word out MSB
// first, one bit every DIV clocks, strobing bit_en in the last clock of each
// bit period. A one-entry holding buffer (plus a same-cycle bypass at the end
// of a frame) lets consecutive words go out with no idle gap.
module piso_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input logic        clk,
  input logic        rs,
  piso_tx_if.slave   io_bus
);

  localparam int               BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_buf;
  logic             r_full;
  logic [7:0]       r_div;
  logic [BIT_W-1:0] r_bit;

  state_t           w_stateNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_bufNext;
  logic             w_fullNext;
  logic [7:0]       w_divNext;
  logic [BIT_W-1:0] w_bitNext;

  logic w_shifting;
  logic w_divLast;
  logic w_bitLast;
  logic w_done;

  assign w_shifting = (r_state == SHIFT);
  assign w_divLast  = (r_div == DIV_LAST);
  assign w_bitLast  = (r_bit == BIT_LAST);
  assign w_done     = w_shifting && w_divLast && w_bitLast;

  assign io_bus.ready  = !r_full;
  assign io_bus.busy   = w_shifting;
  assign io_bus.dout   = w_shifting && r_shift[WIDTH-1];
  assign io_bus.bit_en = w_shifting && w_divLast;
  assign io_bus.done   = w_done;

  // Register update; reset discards any frame in flight and the buffered word.
  always_ff @(posedge clk) begin
    if (rs) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_div   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_shift <= w_shiftNext;
      r_buf   <= w_bufNext;
      r_full  <= w_fullNext;
      r_div   <= w_divNext;
      r_bit   <= w_bitNext;
    end
  end

  // Next-state logic: start a frame from IDLE, time bits with the divider,
  // and at the end of a frame chain straight into the buffered or bypassed word.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_bufNext   = r_buf;
    w_fullNext  = r_full;
    w_divNext   = r_div;
    w_bitNext   = r_bit;

    case (r_state)
      IDLE: begin
        if (io_bus.load) begin
          w_shiftNext = io_bus.din;
          w_divNext   = '0;
          w_bitNext   = '0;
          w_stateNext = SHIFT;
        end
      end

      SHIFT: begin
        // A load in the final cycle of a frame bypasses the buffer instead.
        if (io_bus.load && !r_full && !w_done) begin
          w_bufNext  = io_bus.din;
          w_fullNext = 1'b1;
        end

        if (w_divLast) begin
          w_divNext   = '0;
          w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
          if (w_bitLast) begin
            w_bitNext = '0;
            if (r_full) begin
              w_shiftNext = r_buf;
              w_fullNext  = 1'b0;
            end else if (io_bus.load) begin
              w_shiftNext = io_bus.din;
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            w_bitNext = r_bit + BIT_W'(1);
          end
        end else begin
          w_divNext = r_div + 8'd1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: one instance with DIV=1 and one with DIV=4, a
// table of per-cycle vectors, hand-written multi-cycle sequences, and a
// randomized run against a frame-position reference model.
module tb_piso_tx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rs;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) if1 ();
  piso_tx_if #(.WIDTH(W)) if4 ();

  piso_tx #(.WIDTH(W), .DIV(1)) u1 (.clk(clk), .rs(rs), .io_bus(if1));
  piso_tx #(.WIDTH(W), .DIV(4)) u4 (.clk(clk), .rs(rs), .io_bus(if4));

  // Expected output packing: {dout, busy, bit_en, done, ready}
  typedef struct {
    logic       rs;
    logic       load;
    logic [7:0] din;
    logic [4:0] expOut;
  } tbVec_t;

  tbVec_t vecQ[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a frame is described by its word and a position
  // 0..W*DIV-1; bit index, strobe and end-of-frame follow by arithmetic.
  int         divOf[2] = '{1, 4};
  bit         mAct[2];
  int         mPos[2];
  logic [7:0] mWord[2];
  logic [7:0] mPend[2];
  bit         mPendV[2];
  logic [7:0] rx[2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l1, input logic [7:0] d1,
                               input logic l4, input logic [7:0] d4);
    @(negedge clk);
    rs       = r;
    if1.load = l1;
    if1.din  = d1;
    if4.load = l4;
    if4.din  = d4;
    #1;
  endtask

  function automatic logic [4:0] outs(input int id);
    if (id == 0) return {if1.dout, if1.busy, if1.bit_en, if1.done, if1.ready};
    return {if4.dout, if4.busy, if4.bit_en, if4.done, if4.ready};
  endfunction

  function automatic logic [4:0] modelOut(input int id);
    int   d;
    logic b;
    d = divOf[id];
    if (!mAct[id]) return {4'b0000, !mPendV[id]};
    b = mWord[id][W - 1 - mPos[id] / d];
    return {b, 1'b1, (mPos[id] % d) == d - 1, mPos[id] == W * d - 1, !mPendV[id]};
  endfunction

  task automatic modelStep(input int id, input logic r, input logic l, input logic [7:0] d);
    int dv;
    bit fin;
    dv = divOf[id];
    if (r) begin
      mAct[id]   = 1'b0;
      mPendV[id] = 1'b0;
      mPos[id]   = 0;
      return;
    end
    if (!mAct[id]) begin
      if (l) begin
        mAct[id]  = 1'b1;
        mWord[id] = d;
        mPos[id]  = 0;
      end
      return;
    end
    fin = (mPos[id] == W * dv - 1);
    if (l && !mPendV[id] && !fin) begin
      mPend[id]  = d;
      mPendV[id] = 1'b1;
    end
    if (fin) begin
      mPos[id] = 0;
      if (mPendV[id]) begin
        mWord[id]  = mPend[id];
        mPendV[id] = 1'b0;
      end else if (l) begin
        mWord[id] = d;
      end else begin
        mAct[id] = 1'b0;
      end
    end else begin
      mPos[id]++;
    end
  endtask

  task automatic addVec(input logic l, input logic [7:0] d, input logic [4:0] e);
    vecQ.push_back('{rs: 1'b0, load: l, din: d, expOut: e});
  endtask

  initial begin
    logic [4:0] o;
    logic [4:0] e;
    logic [7:0] rxw;
    logic [7:0] word;
    int         busyCnt;
    int         doneCnt;
    int         doneCyc;
    int         quiet;
    logic       lr[2];
    logic [7:0] dr[2];
    logic       r;
    int         loadPct;

    // Back-to-back via the buffer: 3C, then C3 buffered, then AA dropped.
    addVec(1'b1, 8'h3C, 5'b00001);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b1, 8'hC3, 5'b11101);
    addVec(1'b1, 8'hAA, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b11100);
    addVec(1'b0, 8'h00, 5'b01100);
    addVec(1'b0, 8'h00, 5'b01110);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11111);
    addVec(1'b0, 8'h00, 5'b00001);
    // Bypass: 0F loaded exactly in the done cycle of F0.
    addVec(1'b1, 8'hF0, 5'b00001);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b1, 8'h0F, 5'b01111);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b01101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11101);
    addVec(1'b0, 8'h00, 5'b11111);
    addVec(1'b0, 8'h00, 5'b00001);

    for (int i = 0; i < 2; i++) begin
      mAct[i]   = 1'b0;
      mPos[i]   = 0;
      mWord[i]  = '0;
      mPend[i]  = '0;
      mPendV[i] = 1'b0;
      rx[i]     = '0;
    end

    rs       = 1'b1;
    if1.load = 1'b1;
    if1.din  = 8'hFF;
    if4.load = 1'b1;
    if4.din  = 8'hFF;

    // Reset held 3 cycles with load asserted.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF);
      if (c > 0) begin
        checkOutput($sformatf("rst_div1_c%0d", c), outs(0), 5'b00001);
        checkOutput($sformatf("rst_div4_c%0d", c), outs(1), 5'b00001);
      end
    end
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      checkOutput($sformatf("post_rst_div1_c%0d", c), outs(0), 5'b00001);
      checkOutput($sformatf("post_rst_div4_c%0d", c), outs(1), 5'b00001);
    end

    // Single word A5 at DIV=1 with a receiver shifting on bit_en.
    word = 8'hA5;
    applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    checkOutput("a5_idle", outs(0), 5'b00001);
    rxw = '0;
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      o = outs(0);
      checkOutput($sformatf("a5_dout_c%0d", c), o[4], word[8 - c]);
      checkOutput($sformatf("a5_bit_en_c%0d", c), o[2], 1'b1);
      checkOutput($sformatf("a5_done_c%0d", c), o[1], (c == 8));
      if (o[2]) rxw = {rxw[6:0], o[4]};
    end
    checkOutput("a5_rx_word", rxw, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("a5_back_idle", outs(0), 5'b00001);

    // Word 81 at DIV=4: bit timing, strobe spacing, busy length.
    word = 8'h81;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h81);
    checkOutput("div4_idle", outs(1), 5'b00001);
    rxw = '0; busyCnt = 0; doneCnt = 0; doneCyc = -1;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      o = outs(1);
      if (o[3]) busyCnt++;
      if (o[1]) begin
        doneCnt++;
        doneCyc = c;
      end
      checkOutput($sformatf("div4_bit_en_c%0d", c), o[2], (c <= 32) && (c % 4 == 0));
      if (c <= 32) checkOutput($sformatf("div4_dout_c%0d", c), o[4], word[7 - (c - 1) / 4]);
      if (o[2]) rxw = {rxw[6:0], o[4]};
    end
    checkOutput("div4_busy_cycles", busyCnt, 32);
    checkOutput("div4_done_cycle", doneCyc, 32);
    checkOutput("div4_done_count", doneCnt, 1);
    checkOutput("div4_rx_word", rxw, 8'h81);

    // Mid-frame reset with a word buffered.
    applyStimulus(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    checkOutput("mr_bit1", outs(0), 5'b11101);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("mr_bit2_full", outs(0), 5'b11100);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("mr_bit3_full", outs(0), 5'b11100);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("mr_after_reset", outs(0), 5'b00001);
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      o = outs(0);
      if (o[4] || o[3] || o[1]) quiet++;
    end
    checkOutput("mr_nothing_sent", quiet, 0);

    // Table vectors on the DIV=1 instance.
    for (int i = 0; i < vecQ.size(); i++) begin
      applyStimulus(vecQ[i].rs, vecQ[i].load, vecQ[i].din, 1'b0, 8'h00);
      checkOutput($sformatf("vec%0d", i), outs(0), vecQ[i].expOut);
    end

    // Randomized run on both instances against the reference model.
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int id = 0; id < 2; id++) modelStep(id, 1'b1, 1'b0, 8'h00);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      loadPct = ((cyc / 250) % 2 == 1) ? 45 : 6;
      r = ($urandom_range(0, 299) == 0);
      for (int id = 0; id < 2; id++) begin
        lr[id] = ($urandom_range(0, 99) < loadPct);
        dr[id] = 8'($urandom);
      end
      applyStimulus(r, lr[0], dr[0], lr[1], dr[1]);
      for (int id = 0; id < 2; id++) begin
        o = outs(id);
        e = modelOut(id);
        checkOutput($sformatf("rand_div%0d_cyc%0d", divOf[id], cyc), o, e);
        if (o[2]) rx[id] = {rx[id][6:0], o[4]};
        if (e[1]) checkOutput($sformatf("rand_rx_div%0d_cyc%0d", divOf[id], cyc), rx[id], mWord[id]);
        modelStep(id, r, lr[id], dr[id]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
